// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Covers stall bit positions, stall patterns, FSM state codes and the load-use hazard check.
package pipe_ctrl_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int RADDR_WIDTH = 5;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EXE = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = {RADDR_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        PIPE_ST_RUN    = 2'd0,
        PIPE_ST_JPEND  = 2'd1,
        PIPE_ST_SHADOW = 2'd2
    } pipe_st_e;

    // Stall mask that stops every stage from PC up to and including stage 'top'.
    function automatic logic [5:0] stall_upto(input int top);
        logic [5:0] m;
        m = {6{NOSTOP}};
        for (int i = 0; i < 6; i++) begin
            if (i <= top) begin
                m[i] = STOP;
            end else begin
                m[i] = NOSTOP;
            end
        end
        return m;
    endfunction

    // A load in EXE whose destination feeds a source that ID actually reads.
    function automatic logic load_use(
        input logic                   ex_is_load,
        input logic [RADDR_WIDTH-1:0] ex_rd,
        input logic [RADDR_WIDTH-1:0] rs1,
        input logic                   rs1_re,
        input logic [RADDR_WIDTH-1:0] rs2,
        input logic                   rs2_re
    );
        return ex_is_load && (ex_rd != ZERO_REG) &&
               ((rs1_re && (rs1 == ex_rd)) || (rs2_re && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the core datapath and the pipeline controller.
// The controller is the slave side; the datapath (or a bench) is the master.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_if_in;
    logic                   stallreq_exe_in;
    logic                   stallreq_mem_in;
    logic                   jump_req_in;
    logic [ADDR_WIDTH-1:0]  jump_addr_in;
    logic [RADDR_WIDTH-1:0] id_rs1_raddr_in;
    logic                   id_rs1_re_in;
    logic [RADDR_WIDTH-1:0] id_rs2_raddr_in;
    logic                   id_rs2_re_in;
    logic                   ex_is_load_in;
    logic [RADDR_WIDTH-1:0] ex_rd_in;

    logic [5:0]             stall_out;
    logic                   jump_flush_out;
    logic                   jump_out;
    logic [ADDR_WIDTH-1:0]  jump_addr_out;
    logic                   if_discard_out;
    logic                   bus_timeout_out;

    modport master (
        output stallreq_if_in, stallreq_exe_in, stallreq_mem_in,
        output jump_req_in, jump_addr_in,
        output id_rs1_raddr_in, id_rs1_re_in, id_rs2_raddr_in, id_rs2_re_in,
        output ex_is_load_in, ex_rd_in,
        input  stall_out, jump_flush_out, jump_out, jump_addr_out,
        input  if_discard_out, bus_timeout_out
    );

    modport slave (
        input  stallreq_if_in, stallreq_exe_in, stallreq_mem_in,
        input  jump_req_in, jump_addr_in,
        input  id_rs1_raddr_in, id_rs1_re_in, id_rs2_raddr_in, id_rs2_re_in,
        input  ex_is_load_in, ex_rd_in,
        output stall_out, jump_flush_out, jump_out, jump_addr_out,
        output if_discard_out, bus_timeout_out
    );

endinterface

// File: rtl/pipe_ctrl_watchdog.sv
// Bus-hang watchdog: counts consecutive fetch/LSU wait cycles and raises a sticky
// timeout flag once the count reaches STALL_TIMEOUT.
module pipe_ctrl_watchdog #(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic bus_stall_in,
    output logic timeout_out
);

    localparam logic [7:0] WD_MAX = 8'(STALL_TIMEOUT);

    logic [7:0] wd_cnt_q;
    logic [7:0] wd_cnt_d;
    logic       timeout_q;
    logic       timeout_d;

    // Next count (saturating) and sticky flag; the flag sets on the edge the count lands on the limit.
    always_comb begin
        wd_cnt_d  = 8'd0;
        timeout_d = timeout_q;
        if (bus_stall_in) begin
            if (wd_cnt_q == WD_MAX) begin
                wd_cnt_d = wd_cnt_q;
            end else begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
        end else begin
            wd_cnt_d = 8'd0;
        end
        if (wd_cnt_d == WD_MAX) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wd_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stall vector priority mux, jump redirect sequencing
// (immediate, pended across back-end stalls, fetch shadow) and the bus-hang watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    pipe_ctrl_if.slave  bus
);

    pipe_st_e              state_q;
    pipe_st_e              state_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [ADDR_WIDTH-1:0] pend_addr_d;

    logic                  back_stall_s;
    logic                  lu_s;
    logic                  redirect_s;
    logic [ADDR_WIDTH-1:0] redirect_addr_s;
    logic                  timeout_s;

    assign back_stall_s = bus.stallreq_mem_in | bus.stallreq_exe_in;
    assign lu_s = load_use(bus.ex_is_load_in, bus.ex_rd_in,
                           bus.id_rs1_raddr_in, bus.id_rs1_re_in,
                           bus.id_rs2_raddr_in, bus.id_rs2_re_in);

    // Redirect sequencing; a new jump in SHADOW is treated exactly as in RUN.
    always_comb begin
        state_d         = state_q;
        pend_addr_d     = pend_addr_q;
        redirect_s      = 1'b0;
        redirect_addr_s = {ADDR_WIDTH{1'b0}};
        case (state_q)
            PIPE_ST_RUN, PIPE_ST_SHADOW: begin
                if (bus.jump_req_in) begin
                    if (back_stall_s) begin
                        pend_addr_d = bus.jump_addr_in;
                        state_d     = PIPE_ST_JPEND;
                    end else begin
                        redirect_s      = 1'b1;
                        redirect_addr_s = bus.jump_addr_in;
                        state_d         = PIPE_ST_SHADOW;
                    end
                end else if ((state_q == PIPE_ST_SHADOW) && bus.stallreq_if_in) begin
                    state_d = PIPE_ST_SHADOW;
                end else begin
                    state_d = PIPE_ST_RUN;
                end
            end
            PIPE_ST_JPEND: begin
                if (back_stall_s) begin
                    state_d = PIPE_ST_JPEND;
                end else begin
                    redirect_s      = 1'b1;
                    redirect_addr_s = pend_addr_q;
                    state_d         = PIPE_ST_SHADOW;
                end
            end
            default: begin
                state_d = PIPE_ST_RUN;
            end
        endcase
    end

    // Output mux; reset forces a full stop and suppresses any redirect.
    always_comb begin
        bus.stall_out      = {6{NOSTOP}};
        bus.jump_flush_out = 1'b0;
        bus.jump_out       = 1'b0;
        bus.jump_addr_out  = {ADDR_WIDTH{1'b0}};
        bus.if_discard_out = 1'b0;
        if (reset_in) begin
            bus.stall_out = {6{STOP}};
        end else begin
            if (bus.stallreq_mem_in) begin
                bus.stall_out = stall_upto(STALL_MEM);
            end else if (bus.stallreq_exe_in) begin
                bus.stall_out = stall_upto(STALL_EXE);
            end else if (redirect_s) begin
                bus.stall_out = {6{NOSTOP}};
            end else if (lu_s) begin
                bus.stall_out = stall_upto(STALL_ID);
            end else if (bus.stallreq_if_in) begin
                bus.stall_out = stall_upto(STALL_IF);
            end else begin
                bus.stall_out = {6{NOSTOP}};
            end
            bus.jump_flush_out = redirect_s;
            bus.jump_out       = redirect_s;
            bus.jump_addr_out  = redirect_addr_s;
            bus.if_discard_out = (state_q == PIPE_ST_SHADOW);
        end
    end

    // State and pended redirect target.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= PIPE_ST_RUN;
            pend_addr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    pipe_ctrl_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .bus_stall_in (bus.stallreq_mem_in | bus.stallreq_if_in),
        .timeout_out  (timeout_s)
    );

    assign bus.bus_timeout_out = timeout_s;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: a table of combinational stall vectors
// followed by hand-written redirect, shadow, watchdog and reset sequences.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_ctrl_if bus_if ();

    pipe_ctrl #(
        .STALL_TIMEOUT (4)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mem;
        logic       exe;
        logic       ifs;
        logic       is_load;
        logic [4:0] ex_rd;
        logic [4:0] rs1;
        logic       rs1_re;
        logic [4:0] rs2;
        logic       rs2_re;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.stallreq_if_in  = 1'b0;
        bus_if.stallreq_exe_in = 1'b0;
        bus_if.stallreq_mem_in = 1'b0;
        bus_if.jump_req_in     = 1'b0;
        bus_if.jump_addr_in    = 32'h0;
        bus_if.id_rs1_raddr_in = 5'd0;
        bus_if.id_rs1_re_in    = 1'b0;
        bus_if.id_rs2_raddr_in = 5'd0;
        bus_if.id_rs2_re_in    = 1'b0;
        bus_if.ex_is_load_in   = 1'b0;
        bus_if.ex_rd_in        = 5'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();

        //             mem  exe  ifs  load rd     rs1    re1  rs2    re2  stall
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,6'b000000};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 1'b1,5'd0, 1'b0,6'b000111};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 1'b1,5'd0, 1'b0,6'b000000};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,5'd5, 5'd5, 1'b0,5'd0, 1'b0,6'b000000};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,5'd9, 5'd1, 1'b1,5'd9, 1'b1,6'b000111};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,5'd5, 5'd5, 1'b1,5'd5, 1'b1,6'b000000};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,5'd5, 5'd5, 1'b1,5'd0, 1'b0,6'b000111};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,6'b000011};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,5'd5, 5'd5, 1'b1,5'd0, 1'b0,6'b001111};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,6'b011111};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,5'd7, 5'd6, 1'b1,5'd7, 1'b0,6'b000000};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 1'b0,5'd0, 1'b0,6'b001111};

        // Reset state
        tick();
        check("rst_stall", {26'd0, bus_if.stall_out}, 32'h3F);
        check("rst_flush", {31'd0, bus_if.jump_flush_out}, 32'h0);
        check("rst_jump", {31'd0, bus_if.jump_out}, 32'h0);
        check("rst_addr", bus_if.jump_addr_out, 32'h0);
        check("rst_discard", {31'd0, bus_if.if_discard_out}, 32'h0);
        check("rst_timeout", {31'd0, bus_if.bus_timeout_out}, 32'h0);
        rst = 1'b0;
        tick();

        // Combinational stall priority table
        for (int i = 0; i < 12; i++) begin
            bus_if.stallreq_mem_in = vecs[i].mem;
            bus_if.stallreq_exe_in = vecs[i].exe;
            bus_if.stallreq_if_in  = vecs[i].ifs;
            bus_if.ex_is_load_in   = vecs[i].is_load;
            bus_if.ex_rd_in        = vecs[i].ex_rd;
            bus_if.id_rs1_raddr_in = vecs[i].rs1;
            bus_if.id_rs1_re_in    = vecs[i].rs1_re;
            bus_if.id_rs2_raddr_in = vecs[i].rs2;
            bus_if.id_rs2_re_in    = vecs[i].rs2_re;
            settle();
            check($sformatf("vec%0d_stall", i), {26'd0, bus_if.stall_out}, {26'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d_nojump", i),
                  {29'd0, bus_if.jump_out, bus_if.jump_flush_out, bus_if.if_discard_out}, 32'h0);
            tick();
        end
        do_reset();

        // Immediate redirect then one shadow cycle
        bus_if.jump_req_in  = 1'b1;
        bus_if.jump_addr_in = 32'h100;
        settle();
        check("t2_flush", {31'd0, bus_if.jump_flush_out}, 32'h1);
        check("t2_jump", {31'd0, bus_if.jump_out}, 32'h1);
        check("t2_addr", bus_if.jump_addr_out, 32'h100);
        check("t2_stall", {26'd0, bus_if.stall_out}, 32'h0);
        tick();
        idle_inputs();
        settle();
        check("t2_discard", {31'd0, bus_if.if_discard_out}, 32'h1);
        check("t2_pulse", {31'd0, bus_if.jump_out}, 32'h0);
        tick();
        settle();
        check("t2_discard_end", {31'd0, bus_if.if_discard_out}, 32'h0);
        tick();

        // Redirect pended across a 3-cycle LSU stall; a second jump while pending is ignored
        bus_if.stallreq_mem_in = 1'b1;
        bus_if.jump_req_in     = 1'b1;
        bus_if.jump_addr_in    = 32'h200;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("t3_stall%0d", c), {26'd0, bus_if.stall_out}, 32'h1F);
            check($sformatf("t3_noflush%0d", c), {30'd0, bus_if.jump_out, bus_if.jump_flush_out}, 32'h0);
            tick();
            bus_if.jump_addr_in = 32'h300;
        end
        bus_if.stallreq_mem_in = 1'b0;
        bus_if.jump_req_in     = 1'b0;
        settle();
        check("t3_redirect", {30'd0, bus_if.jump_out, bus_if.jump_flush_out}, 32'h3);
        check("t3_addr", bus_if.jump_addr_out, 32'h200);
        check("t3_stall_rd", {26'd0, bus_if.stall_out}, 32'h0);
        tick();
        settle();
        check("t3_shadow", {31'd0, bus_if.if_discard_out}, 32'h1);
        check("t3_once", {31'd0, bus_if.jump_out}, 32'h0);
        tick();

        // Jump overrides load-use; shadow held while fetch waits
        bus_if.jump_req_in     = 1'b1;
        bus_if.jump_addr_in    = 32'h400;
        bus_if.ex_is_load_in   = 1'b1;
        bus_if.ex_rd_in        = 5'd3;
        bus_if.id_rs1_raddr_in = 5'd3;
        bus_if.id_rs1_re_in    = 1'b1;
        settle();
        check("t4_stall", {26'd0, bus_if.stall_out}, 32'h0);
        check("t4_flush", {31'd0, bus_if.jump_flush_out}, 32'h1);
        check("t4_addr", bus_if.jump_addr_out, 32'h400);
        tick();
        idle_inputs();
        bus_if.stallreq_if_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus_if.stallreq_if_in = 1'b0;
            settle();
            check($sformatf("t4_discard%0d", c), {31'd0, bus_if.if_discard_out}, 32'h1);
            tick();
        end
        settle();
        check("t4_discard_end", {31'd0, bus_if.if_discard_out}, 32'h0);
        tick();

        // Jump from SHADOW while EXE busy goes to pending, then redirects
        bus_if.jump_req_in  = 1'b1;
        bus_if.jump_addr_in = 32'h600;
        tick();
        bus_if.jump_addr_in    = 32'h700;
        bus_if.stallreq_exe_in = 1'b1;
        settle();
        check("t7_exe_stall", {26'd0, bus_if.stall_out}, 32'h0F);
        check("t7_noflush", {31'd0, bus_if.jump_flush_out}, 32'h0);
        tick();
        idle_inputs();
        settle();
        check("t7_redirect", {31'd0, bus_if.jump_out}, 32'h1);
        check("t7_addr", bus_if.jump_addr_out, 32'h700);
        tick();

        // Watchdog with STALL_TIMEOUT=4
        do_reset();
        bus_if.stallreq_mem_in = 1'b1;
        tick();
        tick();
        tick();
        check("t5_not_yet", {31'd0, bus_if.bus_timeout_out}, 32'h0);
        tick();
        check("t5_timeout", {31'd0, bus_if.bus_timeout_out}, 32'h1);
        check("t5_stall", {26'd0, bus_if.stall_out}, 32'h1F);
        bus_if.stallreq_mem_in = 1'b0;
        tick();
        tick();
        check("t5_sticky", {31'd0, bus_if.bus_timeout_out}, 32'h1);

        // Reset in the middle of a pending redirect
        do_reset();
        bus_if.stallreq_mem_in = 1'b1;
        bus_if.jump_req_in     = 1'b1;
        bus_if.jump_addr_in    = 32'h500;
        tick();
        bus_if.jump_req_in     = 1'b0;
        bus_if.stallreq_mem_in = 1'b0;
        rst = 1'b1;
        settle();
        check("t6_rst_stall", {26'd0, bus_if.stall_out}, 32'h3F);
        check("t6_rst_nojump", {30'd0, bus_if.jump_out, bus_if.jump_flush_out}, 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check("t6_no_stale", {30'd0, bus_if.jump_out, bus_if.jump_flush_out}, 32'h0);
        check("t6_run_stall", {26'd0, bus_if.stall_out}, 32'h0);
        check("t6_no_discard", {31'd0, bus_if.if_discard_out}, 32'h0);
        tick();
        settle();
        check("t6_still_quiet", {31'd0, bus_if.jump_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
